// File: rtl/lf_edge_modulator.sv
// lf_edge_modulator: serialises bytes MSB first onto one antenna-modulation
// line using NRZ or Manchester coding. Each half-bit lasts a programmable
// number of clk cycles. A holding register behind the shifter lets bytes
// follow each other with no gap. A frame ends with a low tail.
// edge_state and edge_toggle copy the observables of the LF edge detector.
// Optional build macro LF_TX_PREAMBLE_EN: sends PREAMBLE before the first
// data byte of every frame.
module lf_edge_modulator #(
   parameter int         HALF_W      = 16,
   parameter int         TAIL_HALVES = 2,
   parameter logic [7:0] PREAMBLE    = 8'hF0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HALF_W-1:0] half_period,
   input  logic              manchester,
   input  logic [7:0]        data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              busy,
   output logic              mod_out,
   output logic              edge_state,
   output logic              edge_toggle
);

   localparam int TAIL_W = (TAIL_HALVES > 2) ? $clog2(TAIL_HALVES) : 1;

`ifdef LF_TX_PREAMBLE_EN
   typedef enum logic [1:0] {IDLE, PRE, SHIFT, TAIL} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
   // Keeps the preamble parameter referenced when the feature is not built
   logic unused_preamble;
   assign unused_preamble = ^PREAMBLE;
`endif

   state_t              state_reg, state_next;
   logic [7:0]          shift_reg, shift_next;
   logic [2:0]          bit_cnt_reg, bit_cnt_next;
   logic                second_reg, second_next;     // 1 = second half of the bit
   logic [HALF_W-1:0]   half_cnt_reg, half_cnt_next;
   logic [HALF_W-1:0]   reload_reg, reload_next;     // max(half_period,1)-1, latched per frame
   logic                man_reg, man_next;
   logic [TAIL_W-1:0]   tail_cnt_reg, tail_cnt_next;
   logic [7:0]          hold_reg, hold_next;
   logic                hold_full_reg, hold_full_next;
   logic                mod_reg, mod_next;
   logic                state_copy_reg;
   logic                toggle_reg, toggle_next;

   logic                transfer;
   logic                half_done;
   logic                load_hold;
   logic [HALF_W-1:0]   start_reload;

   // Line level of one half of a bit in the selected coding
   function automatic logic level(input logic b, input logic second, input logic man);
      return man ? (b ^ second) : b;
   endfunction

   assign transfer     = data_valid && !hold_full_reg;
   assign half_done    = (half_cnt_reg == '0);
   assign start_reload = (half_period == '0) ? '0 : (half_period - 1'b1);

   assign data_ready  = !hold_full_reg;
   assign busy        = (state_reg != IDLE);
   assign mod_out     = mod_reg;
   assign edge_state  = state_copy_reg;
   assign edge_toggle = toggle_reg;

   // Next-state, shifter, half-bit timing, holding register and line level
   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      second_next   = second_reg;
      half_cnt_next = half_cnt_reg;
      reload_next   = reload_reg;
      man_next      = man_reg;
      tail_cnt_next = tail_cnt_reg;
      mod_next      = mod_reg;
      load_hold     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (hold_full_reg) begin
               reload_next   = start_reload;
               man_next      = manchester;
               half_cnt_next = start_reload;
               bit_cnt_next  = 3'd7;
               second_next   = 1'b0;
`ifdef LF_TX_PREAMBLE_EN
               // The data byte waits in the holding register behind the preamble
               state_next    = PRE;
               shift_next    = PREAMBLE;
               mod_next      = level(PREAMBLE[7], 1'b0, manchester);
`else
               state_next    = SHIFT;
               shift_next    = hold_reg;
               load_hold     = 1'b1;
               mod_next      = level(hold_reg[7], 1'b0, manchester);
`endif
            end
         end
`ifdef LF_TX_PREAMBLE_EN
         PRE, SHIFT: begin
`else
         SHIFT: begin
`endif
            if (!half_done) begin
               half_cnt_next = half_cnt_reg - 1'b1;
            end else if (!second_reg) begin
               second_next   = 1'b1;
               half_cnt_next = reload_reg;
               mod_next      = level(shift_reg[7], 1'b1, man_reg);
            end else if (bit_cnt_reg != 3'd0) begin
               shift_next    = {shift_reg[6:0], 1'b0};
               bit_cnt_next  = bit_cnt_reg - 1'b1;
               second_next   = 1'b0;
               half_cnt_next = reload_reg;
               mod_next      = level(shift_reg[6], 1'b0, man_reg);
            end else if (hold_full_reg) begin
               // Next byte follows without a gap cycle
               state_next    = SHIFT;
               shift_next    = hold_reg;
               load_hold     = 1'b1;
               bit_cnt_next  = 3'd7;
               second_next   = 1'b0;
               half_cnt_next = reload_reg;
               mod_next      = level(hold_reg[7], 1'b0, man_reg);
            end else if (TAIL_HALVES == 0) begin
               state_next    = IDLE;
               mod_next      = 1'b0;
            end else begin
               state_next    = TAIL;
               tail_cnt_next = TAIL_W'(TAIL_HALVES - 1);
               half_cnt_next = reload_reg;
               mod_next      = 1'b0;
            end
         end
         TAIL: begin
            if (!half_done) begin
               half_cnt_next = half_cnt_reg - 1'b1;
            end else if (tail_cnt_reg == '0) begin
               state_next    = IDLE;
            end else begin
               tail_cnt_next = tail_cnt_reg - 1'b1;
               half_cnt_next = reload_reg;
            end
         end
         default: begin
            state_next = IDLE;
            mod_next   = 1'b0;
         end
      endcase

      // A new byte wins over a same-cycle load, leaving the holding register full
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      if (load_hold) begin
         hold_full_next = 1'b0;
      end
      if (transfer) begin
         hold_next      = data_in;
         hold_full_next = 1'b1;
      end

      toggle_next = toggle_reg ^ (mod_next != mod_reg);
   end

   // All state registers; reset aborts any frame at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         bit_cnt_reg    <= '0;
         second_reg     <= 1'b0;
         half_cnt_reg   <= '0;
         reload_reg     <= '0;
         man_reg        <= 1'b0;
         tail_cnt_reg   <= '0;
         hold_reg       <= '0;
         hold_full_reg  <= 1'b0;
         mod_reg        <= 1'b0;
         state_copy_reg <= 1'b0;
         toggle_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         bit_cnt_reg    <= bit_cnt_next;
         second_reg     <= second_next;
         half_cnt_reg   <= half_cnt_next;
         reload_reg     <= reload_next;
         man_reg        <= man_next;
         tail_cnt_reg   <= tail_cnt_next;
         hold_reg       <= hold_next;
         hold_full_reg  <= hold_full_next;
         mod_reg        <= mod_next;
         state_copy_reg <= mod_next;
         toggle_reg     <= toggle_next;
      end
   end

endmodule

// File: tb/tb_lf_edge_modulator.sv
// Testbench for lf_edge_modulator. A behavioural model turns each frame
// (a list of bytes, the half period and the coding) into the expected
// per-cycle mod_out waveform and the expected byte-acceptance times.
// Directed and random frames are compared against the design.
module tb_lf_edge_modulator;
   localparam int         HALF_W      = 16;
   localparam int         TAIL_HALVES = 2;
   localparam logic [7:0] PREAMBLE    = 8'hF0;
`ifdef LF_TX_PREAMBLE_EN
   localparam int PRE_BYTES = 1;
`else
   localparam int PRE_BYTES = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [HALF_W-1:0] half_period;
   logic              manchester;
   logic [7:0]        data_in;
   logic              data_valid;
   logic              data_ready;
   logic              busy;
   logic              mod_out;
   logic              edge_state;
   logic              edge_toggle;

   int checks = 0;
   int errors = 0;

   lf_edge_modulator #(
      .HALF_W      (HALF_W),
      .TAIL_HALVES (TAIL_HALVES),
      .PREAMBLE    (PREAMBLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .half_period (half_period),
      .manchester  (manchester),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .busy        (busy),
      .mod_out     (mod_out),
      .edge_state  (edge_state),
      .edge_toggle (edge_toggle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Sends one frame, offering bytes whenever the design is ready, and
   // compares every cycle against the modelled waveform.
   task automatic run_frame(input string tag, input logic [7:0] bytes[$], input int hp,
                            input bit man, input bit scramble,
                            output int busy_o, output int tog_o);
      bit         wave[$];
      logic [7:0] all_bytes[$];
      int         xfer_edge[$];
      int         hpe, n, idx, s, busy_cnt, tog_cnt, wave_err, first_err, exp_tog;
      bit         started, done, xfer, prev_tog, v, v2;

      hpe = (hp == 0) ? 1 : hp;
      n   = bytes.size();

      // Model: idle sample, halves of every bit, tail, back to idle
      if (PRE_BYTES != 0) all_bytes.push_back(PREAMBLE);
      foreach (bytes[j]) all_bytes.push_back(bytes[j]);
      wave.push_back(1'b0);
      foreach (all_bytes[j]) begin
         for (int b = 7; b >= 0; b--) begin
            v  = all_bytes[j][b];
            v2 = man ? ~v : v;
            repeat (hpe) wave.push_back(v);
            repeat (hpe) wave.push_back(v2);
         end
      end
      repeat (TAIL_HALVES * hpe) wave.push_back(1'b0);
      wave.push_back(1'b0);
      exp_tog = 0;
      for (int i = 1; i < wave.size(); i++) if (wave[i] != wave[i-1]) exp_tog++;

      half_period = HALF_W'(hp);
      manchester  = man;
      idx = 0; s = 0; busy_cnt = 0; tog_cnt = 0; wave_err = 0; first_err = -1;
      started = 0; done = 0;
      prev_tog = edge_toggle;

      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (started) begin
            if (scramble && s > 0) begin
               half_period = HALF_W'($urandom_range(0, 6));
               manchester  = 1'($urandom_range(0, 1));
            end
            if (mod_out !== wave[s] || edge_state !== wave[s] ||
                busy !== (s > 0 && s < wave.size() - 1)) begin
               wave_err++;
               if (first_err < 0) first_err = s;
            end
            if (busy === 1'b1) busy_cnt++;
            if (edge_toggle !== prev_tog) tog_cnt++;
            prev_tog = edge_toggle;
            s++;
            if (s == wave.size()) done = 1;
         end
         data_valid = (idx < n) && !done;
         data_in    = (idx < n) ? bytes[idx] : 8'($urandom);
         xfer       = data_valid && (data_ready === 1'b1);
         if (done) break;
         @(posedge clk);
         if (xfer) begin
            if (!started) started = 1;
            else xfer_edge.push_back(s);
            idx++;
         end
      end
      data_valid  = 1'b0;
      half_period = HALF_W'(hp);
      manchester  = man;

      check({tag, "_complete"}, done, 1);
      check({tag, "_wave_err"}, wave_err, 0);
      if (wave_err != 0) $display("  %s first bad sample %0d", tag, first_err);
      check({tag, "_busy_cycles"}, busy_cnt, wave.size() - 2);
      check({tag, "_toggles"}, tog_cnt, exp_tog);
      check({tag, "_transfers"}, idx, n);
      if (xfer_edge.size() == n - 1) begin
         foreach (xfer_edge[k])
            check({tag, "_xfer_time"}, xfer_edge[k], 2 + (k + PRE_BYTES) * 16 * hpe);
      end else begin
         check({tag, "_xfer_count"}, xfer_edge.size(), n - 1);
      end
      $display("frame %s bytes=%0d hp=%0d man=%0d cycles=%0d toggles=%0d", tag, n, hp, man, busy_cnt, tog_cnt);
      busy_o = busy_cnt;
      tog_o  = tog_cnt;
   endtask

   initial begin
      logic [7:0] q[$];
      int         bc, tc, nb, hp;
      bit         man, t0;

      rst_n = 1'b0; data_valid = 1'b0; data_in = 8'h00;
      half_period = '0; manchester = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mod_out", mod_out, 0);
      check("rst_busy", busy, 0);
      check("rst_edge_state", edge_state, 0);
      check("rst_edge_toggle", edge_toggle, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_data_ready", data_ready, 1);
      check("rst_busy_after", busy, 0);

      // Manchester single byte 0xA5, half period 3
      q = {}; q.push_back(8'hA5);
      run_frame("man_a5", q, 3, 1'b1, 1'b0, bc, tc);
      if (PRE_BYTES == 0) begin
         check("man_a5_busy54", bc, 54);
         check("man_a5_tog10", tc, 10);
      end

      // NRZ back-to-back, half period 0 behaves as 1
      q = {}; q.push_back(8'h81); q.push_back(8'h7E);
      run_frame("nrz_b2b", q, 0, 1'b0, 1'b0, bc, tc);

      // Three bytes offered continuously: the third waits for the holding register
      q = {}; q.push_back(8'h3C); q.push_back(8'hC3); q.push_back(8'h55);
      run_frame("hold_full", q, 1, 1'b0, 1'b0, bc, tc);
      if (PRE_BYTES == 0) check("hold_full_busy", bc, 48 + TAIL_HALVES);

      // Preamble case (without the feature this is a plain 0x00 frame)
      q = {}; q.push_back(8'h00);
      run_frame("nrz_00", q, 1, 1'b0, 1'b0, bc, tc);

      // Settings changed mid-frame must not affect the running frame
      q = {}; q.push_back(8'h96); q.push_back(8'h0F);
      run_frame("scramble", q, 2, 1'b1, 1'b1, bc, tc);

      // Asynchronous reset in the middle of bit 4 of a Manchester byte
      @(negedge clk);
      t0 = edge_toggle;
      half_period = HALF_W'(4); manchester = 1'b1;
      data_in = 8'hFF; data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      repeat (26) @(negedge clk);
      check("pre_rst_mod_out", mod_out, 1);
      check("pre_rst_toggle", edge_toggle, !t0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_mod_out", mod_out, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_toggle", edge_toggle, 0);
      check("async_rst_edge_state", edge_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      q = {}; q.push_back(8'hFF);
      run_frame("after_rst_ff", q, 4, 1'b1, 1'b0, bc, tc);

      // Random frames
      for (int r = 0; r < 6; r++) begin
         q  = {};
         nb = $urandom_range(1, 3);
         for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
         hp  = $urandom_range(0, 3);
         man = 1'($urandom_range(0, 1));
         run_frame($sformatf("rand%0d", r), q, hp, man, 1'b1, bc, tc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lf_edge_modulator.md
Name: lf_edge_modulator

Overview:
- LF transmit-side counterpart of the LF edge detector: serialises bytes onto a single antenna-modulation line.
- Coding is NRZ or Manchester, MSB first, with programmable half-bit timing in clk cycles.
- Sits between the ARM/SSP byte interface and the LF power/modulation drive.
- Mirrors the detector's observables: a level (edge_state) and a toggle-per-transition (edge_toggle), so a loopback through the detector reproduces the same toggle count.

Parameters:
- HALF_W, 16, width of half_period input and half-bit counter.
- TAIL_HALVES, 2, number of idle-low half-bit periods emitted after the last byte of a frame.
- PREAMBLE, 8'hF0, preamble byte (used only with LF_TX_PREAMBLE_EN).

Ports:
- clk  in  1  system clock (24 MHz).
- rst_n  in  1  asynchronous active-low reset.
- half_period  in  HALF_W  half-bit duration in clk cycles; 0 is treated as 1; sampled at frame start only.
- manchester  in  1  1 = Manchester, 0 = NRZ; sampled at frame start only.
- data_in  in  8  byte to transmit.
- data_valid  in  1  data_in valid.
- data_ready  out  1  block can accept a byte this cycle.
- busy  out  1  frame in progress (any state other than IDLE).
- mod_out  out  1  modulation drive; 1 = field modulated.
- edge_state  out  1  equals mod_out (registered copy, same cycle).
- edge_toggle  out  1  inverts on every mod_out transition.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; mod_out, edge_state, edge_toggle, busy = 0.
  - Holding register empty; data_ready = 1 once rst_n is released.
  - Reset mid-frame aborts immediately; no tail is emitted.
- Handshake:
  - A byte transfers on a clk edge where data_valid & data_ready.
  - One shift register plus one holding register.
  - data_ready = holding register empty.
  - data_valid may drop at any time with no side effects.
- FSM states: IDLE, PRE, SHIFT, TAIL.
  - IDLE -> SHIFT (or PRE with the feature) on the edge after a transfer.
    - The accepted byte moves to the shifter; half_period and manchester are latched.
    - The first level appears on mod_out one cycle after the transfer edge.
  - SHIFT: each bit lasts 2 half-periods (2*max(half_period,1) cycles).
    - NRZ: both halves = bit.
    - Manchester: bit 1 = high then low; bit 0 = low then high.
  - After bit 0 (LSB) of a byte completes:
    - If the holding register is full, its byte loads into the shifter with no gap cycle and the holding register frees.
    - Otherwise -> TAIL.
  - A transfer arriving in the same cycle as the shifter load is accepted; the holding register stays full with the new byte.
  - TAIL: mod_out = 0 for TAIL_HALVES half-periods, then -> IDLE.
    - data_ready stays high, but a byte accepted during TAIL is held and starts a new frame after IDLE is entered (one IDLE cycle).
- Counter: half-bit counter loads max(half_period,1)-1 and counts down; the half ends when it reaches 0. No wrap is possible because the value is latched per frame.
- mod_out is registered and glitch-free.
- edge_toggle and edge_state update in the same cycle as mod_out.
- busy = (state != IDLE).

Optional Feature:
- LF_TX_PREAMBLE_EN defined:
  - PRE state emits PREAMBLE (8 bits, MSB first, current coding) before the first data byte of each frame.
  - Back-to-back bytes within a frame get no preamble.
  - Holding-register behaviour during PRE is the same as in SHIFT.
- Undefined: the PRE state and PREAMBLE are absent; IDLE goes straight to SHIFT.

Test Plan:
- Manchester, half_period = 3, single byte 0xA5:
  - mod_out halves = H L L H H L L H L H H L L H H L, 3 cycles each (48 cycles).
  - Then 6 low tail cycles; edge_toggle inverts exactly 10 times; busy high for 54 cycles.
- NRZ, half_period = 0 (treated as 1), bytes 0x81 then 0x7E offered back-to-back:
  - The second byte is accepted while the first is shifting.
  - mod_out = 1000000101111110, 2 cycles per bit, with no gap between bytes.
- Holding full: hold data_valid high with a third byte while two bytes are queued:
  - data_ready stays 0 until bit 0 of byte 1 completes.
  - Exactly 3 transfers occur; frame length is 48 bit-cycles plus tail.
- Async reset: assert rst_n low in the middle of bit 4 of a Manchester byte:
  - mod_out, busy and edge_toggle go to 0 without waiting for clk.
  - After release, a new byte 0xFF transmits correctly from bit 7.
- half_period or manchester changed mid-frame: the old values stay in effect until the next IDLE->SHIFT transition.
- With LF_TX_PREAMBLE_EN, NRZ, half_period = 1, byte 0x00:
  - mod_out = 11110000 00000000 (each bit 2 cycles) followed by the tail.
